// File: rtl/match_event_logger.sv
// Timestamped event logger: captures a free-running counter on each det_in pulse into a FIFO.
// Optional saturating discard counter (drop_cnt) is built only when DROP_CNT_EN is defined.
module match_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     det_in,
  output logic [TS_W-1:0]          ts_out,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     full
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 16) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end

  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0] mem_q [DEPTH];
  logic            push, pop;

  assign evt_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign fifo_cnt  = cnt_q;
  // Head is masked to zero when empty so stale storage never leaks out.
  assign ts_out    = evt_valid ? mem_q[rd_q] : '0;

  always_comb begin
    pop   = evt_valid & evt_ready;
    push  = det_in & (~full | pop);
    ts_d  = ts_q + TS_W'(1);
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ts_q  <= ts_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; it is only visible through ts_out while non-empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q] <= ts_q;
  end

`ifdef DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic       drop;

  always_comb begin
    drop   = det_in & full & ~pop;
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Bench for match_event_logger: directed scenarios plus random traffic against a queue model.
// Build with +define+DROP_CNT_EN to also check the discard counter.
module tb_match_event_logger;
  localparam int DEPTH = 4;
  localparam int TS_W  = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   det_in = 1'b0;
  logic                   evt_ready = 1'b0;
  logic [TS_W-1:0]        ts_out;
  logic                   evt_valid;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                   full;
`ifdef DROP_CNT_EN
  logic [7:0]             drop_cnt;
`endif

  match_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .det_in    (det_in),
    .ts_out    (ts_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .fifo_cnt  (fifo_cnt),
    .full      (full)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of timestamps, a wrapping counter and a saturating drop count.
  int q[$];
  int ts_m   = 0;
  int drop_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_cnt"},   32'(fifo_cnt),  32'(q.size()));
    chk({tag, "_valid"}, 32'(evt_valid), 32'(q.size() != 0));
    chk({tag, "_full"},  32'(full),      32'(q.size() == DEPTH));
    chk({tag, "_head"},  32'(ts_out),    (q.size() != 0) ? 32'(q[0]) : 32'd0);
`ifdef DROP_CNT_EN
    chk({tag, "_drop"},  32'(drop_cnt),  32'(drop_m));
`endif
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input logic r, input logic d, input logic rdy, input string tag);
    bit p, pu;
    rst = r; det_in = d; evt_ready = rdy;
    if (r) begin
      q.delete();
      ts_m   = 0;
      drop_m = 0;
    end else begin
      p  = (q.size() != 0) && rdy;
      pu = d && ((q.size() < DEPTH) || p);
      if (p)  void'(q.pop_front());
      if (pu) q.push_back(ts_m);
      else if (d && drop_m < 255) drop_m++;
      ts_m = (ts_m + 1) % (1 << TS_W);
    end
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic idle_to(input int target, input string tag);
    for (int k = 0; k < 300 && ts_m != target; k++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, tag);
    step(1'b1, 1'b0, 1'b0, tag);
    rst = 1'b0;
  endtask

  int exp_drain[4] = '{11, 12, 13, 20};

  initial begin
    @(negedge clk);

    // Reset state
    do_reset("rst");
    chk("rst_cnt0", 32'(fifo_cnt), 32'd0);
    chk("rst_head0", 32'(ts_out), 32'd0);

    // First event at ts=5, held with no consumer
    idle_to(5, "r030_idle");
    step(1'b0, 1'b1, 1'b0, "r030_evt");
    chk("r030_head", 32'(ts_out), 32'd5);
    chk("r030_cnt", 32'(fifo_cnt), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, "r030_hold");
    chk("r030_held", 32'(ts_out), 32'd5);

    // Six back-to-back events at ts=10..15 into a 4-deep FIFO
    do_reset("r031_rst");
    idle_to(10, "r031_idle");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, "r031_burst");
    chk("r031_full", 32'(full), 32'd1);
    chk("r031_head", 32'(ts_out), 32'd10);
`ifdef DROP_CNT_EN
    chk("r031_drop", 32'(drop_cnt), 32'd2);
`endif

    // Simultaneous push and pop while full, then drain
    idle_to(20, "r032_idle");
    step(1'b0, 1'b1, 1'b1, "r032_pp");
    chk("r032_cnt", 32'(fifo_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("r032_order", 32'(ts_out), 32'(exp_drain[i]));
      step(1'b0, 1'b0, 1'b1, "r032_drain");
    end
    chk("r032_empty", 32'(evt_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, "r024_ready_empty");

    // Timestamp wrap: events at 255 then 0
    do_reset("r033_rst");
    idle_to(255, "r033_idle");
    step(1'b0, 1'b1, 1'b0, "r033_e255");
    step(1'b0, 1'b1, 1'b0, "r033_e0");
    chk("r033_first", 32'(ts_out), 32'd255);
    step(1'b0, 1'b0, 1'b1, "r033_pop");
    chk("r033_second", 32'(ts_out), 32'd0);
    chk("r033_valid", 32'(evt_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, "r033_pop2");

    // Reset flushes buffered events and ignores det_in
    step(1'b0, 1'b1, 1'b0, "r034_fill");
    step(1'b0, 1'b1, 1'b0, "r034_fill");
    step(1'b0, 1'b1, 1'b0, "r034_fill");
    step(1'b1, 1'b1, 1'b1, "r034_rst");
    rst = 1'b0;
    chk("r034_cnt", 32'(fifo_cnt), 32'd0);
    chk("r034_valid", 32'(evt_valid), 32'd0);
    idle_to(3, "r034_idle");
    step(1'b0, 1'b1, 1'b0, "r034_evt");
    chk("r034_ts_restart", 32'(ts_out), 32'd3);

    // 300 discards while full
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "r035_fill");
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, "r035_drop");
    chk("r035_head", 32'(ts_out), 32'd3);
`ifdef DROP_CNT_EN
    chk("r035_sat", 32'(drop_cnt), 32'd255);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, "r035_drain");

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0) ? 1'($urandom_range(0, 1)) : 1'b1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
